button_event_decoder: RTL and testbench

//  Consumes a clean, debounced button level and turns it into discrete UI events:
//  - one-cycle press and release strobes
//  - a long-press strobe after a programmable hold time
//  - periodic auto-repeat strobes while the button stays held

---
 rtl/button_event_decoder.sv | 159 +++++++++++++++
 tb/tb_button_event_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns a clean, debounced button level into discrete UI strobes for the
// stopwatch control FSM: press, release, long-press and periodic auto-repeat.
// A button that is already down when reset is released is ignored until it
// has been seen released once, so a stuck or held key never fakes a press.
//
// Ports
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   button_in      in   debounced level, 1 = pressed
//   press_pulse    out  1-cycle strobe, press recognised
//   release_pulse  out  1-cycle strobe, release after a recognised press
//   long_press     out  1-cycle strobe, hold time reached
//   repeat_pulse   out  1-cycle strobe, auto-repeat tick while held
//   held           out  level, high while a recognised press is in progress
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int CNT_W         = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_HELD    = 2'd3
  } state_e;

  // Terminal counts: the counter starts at 0 on the first cycle in a state,
  // so the event fires when it has counted N-1.
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // Next-state, counter and strobe decode; strobes default low every cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = 1'b0;

    case (state_q)
      ST_ARM: begin
        // Wait for the button to be seen up before accepting presses.
        if (button_in == 1'b0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
        cnt_d = CNT_ZERO;
      end

      ST_IDLE: begin
        if (button_in == 1'b1) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
        cnt_d = CNT_ZERO;
      end

      ST_PRESSED: begin
        // Release is tested first so it wins over a coincident long-press.
        if (button_in == 1'b0) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          cnt_d     = CNT_ZERO;
        end else if (cnt_q == HOLD_TC) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (button_in == 1'b0) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          cnt_d     = CNT_ZERO;
        end else if (REPEAT_EN == 1'b0) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == REPEAT_TC) begin
          repeat_d = 1'b1;
          cnt_d    = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_ARM;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // held tracks the state being entered, so it is registered with the strobes.
    if ((state_d == ST_PRESSED) || (state_d == ST_HELD)) begin
      held_d = 1'b1;
    end else begin
      held_d = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARM;
      cnt_q     <= CNT_ZERO;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Drives two decoders from the same button/reset stimulus: one with auto-repeat
// enabled and one with it disabled. Expected strobes come from a reference
// model that counts edges since the recognised press and derives each event
// arithmetically from that count.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int CW = 8;
  localparam int H  = 4;
  localparam int R  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_in;
  logic [1:0] pp, rlp, lp, rpp, hd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, index 0 = repeat enabled, 1 = repeat disabled.
  bit m_blocked  [2];
  bit m_pressing [2];
  int m_n        [2];
  bit e_press    [2];
  bit e_rel      [2];
  bit e_long     [2];
  bit e_rep      [2];
  bit e_held     [2];
  bit cfg_rep    [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  button_event_decoder #(
    .CNT_W(CW), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .button_in(button_in),
    .press_pulse(pp[0]), .release_pulse(rlp[0]), .long_press(lp[0]),
    .repeat_pulse(rpp[0]), .held(hd[0])
  );

  button_event_decoder #(
    .CNT_W(CW), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)
  ) dut_norep (
    .clk(clk), .rst(rst), .button_in(button_in),
    .press_pulse(pp[1]), .release_pulse(rlp[1]), .long_press(lp[1]),
    .repeat_pulse(rpp[1]), .held(hd[1])
  );

  // n = edges since the press edge; long at n==H, repeats at n==H+j*R.
  task automatic model_edge(input int k, input bit b, input bit r);
    e_press[k] = 1'b0;
    e_rel[k]   = 1'b0;
    e_long[k]  = 1'b0;
    e_rep[k]   = 1'b0;
    if (r) begin
      m_blocked[k]  = 1'b1;
      m_pressing[k] = 1'b0;
      m_n[k]        = 0;
    end else if (m_pressing[k]) begin
      m_n[k] = m_n[k] + 1;
      if (!b) begin
        e_rel[k]      = 1'b1;
        m_pressing[k] = 1'b0;
      end else if (m_n[k] == H) begin
        e_long[k] = 1'b1;
      end else if (cfg_rep[k] && (m_n[k] > H) && (((m_n[k] - H) % R) == 0)) begin
        e_rep[k] = 1'b1;
      end
    end else if (m_blocked[k]) begin
      if (!b) m_blocked[k] = 1'b0;
    end else if (b) begin
      e_press[k]    = 1'b1;
      m_pressing[k] = 1'b1;
      m_n[k]        = 0;
    end
    e_held[k] = m_pressing[k];
  endtask

  task automatic check(input string tag, input logic obs, input bit exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after it.
  task automatic step(input bit b, input bit r);
    button_in = b;
    rst       = r;
    @(posedge clk);
    cyc++;
    model_edge(0, b, r);
    model_edge(1, b, r);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("press[%0d]", k),   pp[k],  e_press[k]);
      check($sformatf("release[%0d]", k), rlp[k], e_rel[k]);
      check($sformatf("long[%0d]", k),    lp[k],  e_long[k]);
      check($sformatf("repeat[%0d]", k),  rpp[k], e_rep[k]);
      check($sformatf("held[%0d]", k),    hd[k],  e_held[k]);
    end
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int  run_left;
    bit  lvl;
    bit  r;

    rst       = 1'b1;
    button_in = 1'b0;

    // Reset state.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Short press: high at t0 and t0+1, low at t0+2.
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b0, 3);

    // Long hold t0..t0+11 (long-press, repeats), release at t0+12.
    run(1'b1, 12);
    run(1'b0, 3);

    // Reset released while held: no press until a 0->1 transition.
    step(1'b1, 1'b1);
    run(1'b1, 5);
    run(1'b0, 1);
    run(1'b1, 1);
    run(1'b0, 2);

    // Release exactly at the long-press edge.
    run(1'b1, 4);
    run(1'b0, 2);

    // Reset while in HELD; held button must not re-press until released.
    run(1'b1, 6);
    step(1'b1, 1'b1);
    run(1'b1, 3);
    run(1'b0, 1);
    run(1'b1, 1);
    run(1'b0, 2);

    // Random button runs with occasional resets.
    run_left = 0;
    lvl      = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        lvl      = ($urandom_range(0, 1) == 1);
        run_left = $urandom_range(1, 16);
      end
      r = ($urandom_range(0, 99) == 0);
      step(lvl, r);
      run_left--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
